fft_input_pingpong: RTL and testbench

Parametrised serial-to-parallel input buffer for the FFT datapath. It collects NPT streamed samples into one of two register banks (ping-pong) and presents a completed frame as a flat parallel bus to the butterfly stages. The next frame is captured while the current one is consumed. It adds valid/ready handshaking, frame resync and overflow flagging, none of which a single-bank free-running capture register has.

---
 rtl/fft_input_pingpong.sv | 101 ++++++++++
 tb/tb_fft_input_pingpong.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_pingpong.sv
// Ping-pong serial-to-parallel frame buffer feeding the FFT butterfly array.
// Optional macro BITREV_EN stores each frame in bit-reversed order for a DIT datapath.
module fft_input_pingpong #(
   parameter int N       = 16,
   parameter int Q       = 8,
   parameter int NPT     = 32,
   parameter int LOG2NPT = 5
) (
   input  logic             clk2,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             in_sof,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [NPT*N-1:0] out_data,
   output logic             ovf
);

   if (LOG2NPT != $clog2(NPT)) begin : g_chk_log2
      $error("fft_input_pingpong: LOG2NPT (%0d) does not match NPT (%0d)", LOG2NPT, NPT);
   end
   if (NPT < 4 || NPT > 1024 || (NPT & (NPT - 1)) != 0) begin : g_chk_npt
      $error("fft_input_pingpong: NPT (%0d) must be a power of two in 4..1024", NPT);
   end
   if (Q < 0 || Q >= N) begin : g_chk_q
      $error("fft_input_pingpong: Q (%0d) must lie in 0..N-1", Q);
   end

   logic [N-1:0]       r_bank [2][NPT];
   logic [LOG2NPT-1:0] r_wr_cnt;
   logic               r_wr_sel;
   logic               r_rd_sel;
   logic [1:0]         r_full;
   logic               r_ovf;

   logic               w_accept;
   logic               w_ack;
   logic               w_last;
   logic [LOG2NPT-1:0] w_addr;
   logic [1:0]         w_full_nxt;

`ifdef BITREV_EN
   function automatic logic [LOG2NPT-1:0] bitrev(input logic [LOG2NPT-1:0] v);
      logic [LOG2NPT-1:0] r;
      for (int i = 0; i < LOG2NPT; i++) r[i] = v[LOG2NPT-1-i];
      return r;
   endfunction

   assign w_addr = in_sof ? '0 : bitrev(r_wr_cnt);
`else
   assign w_addr = in_sof ? '0 : r_wr_cnt;
`endif

   // The write bank is only ever blocked when both banks hold unread frames.
   assign in_ready  = ~r_full[r_wr_sel];
   assign out_valid = r_full[r_rd_sel];
   assign ovf       = r_ovf;
   assign w_accept  = in_valid & in_ready;
   assign w_ack     = out_valid & out_ack;
   assign w_last    = w_accept & ~in_sof & (r_wr_cnt == LOG2NPT'(NPT - 1));

   for (genvar k = 0; k < NPT; k++) begin : g_out
      assign out_data[k*N +: N] = r_bank[r_rd_sel][k];
   end

   // A completing write and an ack always target different banks, so both apply.
   always_comb begin
      // NOTE: default first so every path assigns w_full_nxt and no latch is inferred.
      w_full_nxt = r_full;
      if (w_ack)  w_full_nxt[r_rd_sel] = 1'b0;
      if (w_last) w_full_nxt[r_wr_sel] = 1'b1;
   end

   always_ff @(posedge clk2 or posedge rst) begin
      if (rst) begin
         // NOTE: banks are reset because out_data must read zero straight out of reset.
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NPT; k++) r_bank[b][k] <= '0;
         end
         r_wr_cnt <= '0;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_full   <= 2'b00;
         r_ovf    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         if (w_accept) begin
            r_bank[r_wr_sel][w_addr] <= in_data;
            if (in_sof) r_wr_cnt <= LOG2NPT'(1);
            else        r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         if (w_last) r_wr_sel <= ~r_wr_sel;
         if (w_ack)  r_rd_sel <= ~r_rd_sel;
         r_full <= w_full_nxt;
         if (in_valid & ~in_ready) r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_input_pingpong.sv
// Self-checking bench for fft_input_pingpong: frame-queue model plus directed scenarios.
// Honours BITREV_EN the same way as the design.
module tb_fft_input_pingpong;

   localparam int N       = 16;
   localparam int NPT     = 32;
   localparam int LOG2NPT = 5;
   localparam int BW      = NPT * N;

   typedef logic [N-1:0] frame_t [NPT];

   logic          clk2 = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_data = '0;
   logic          in_sof = 1'b0;
   logic          out_ack = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          ovf;
   logic [BW-1:0] out_data;

   int checks = 0;
   int failures = 0;

   frame_t       q_frames[$];
   logic [N-1:0] q_partial[$];
   logic         mdl_ovf = 1'b0;

   fft_input_pingpong #(.N(N), .Q(8), .NPT(NPT), .LOG2NPT(LOG2NPT)) dut (
      .clk2     (clk2),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_sof   (in_sof),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ack  (out_ack),
      .out_data (out_data),
      .ovf      (ovf)
   );

   always #5 clk2 = ~clk2;

   // Slot in out_data where the i-th sample of a frame lands.
   function automatic int slot_of(input int i);
`ifdef BITREV_EN
      int r = 0;
      for (int b = 0; b < LOG2NPT; b++) if (((i >> b) & 1) == 1) r = r | (1 << (LOG2NPT - 1 - b));
      return r;
`else
      return i;
`endif
   endfunction

   function automatic logic [BW-1:0] expected_bus(input frame_t f);
      logic [BW-1:0] v = '0;
      for (int i = 0; i < NPT; i++) v[slot_of(i)*N +: N] = f[i];
      return v;
   endfunction

   function automatic logic [N-1:0] slot(input int k);
      return out_data[k*N +: N];
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the frame-queue model, then model update.
   always @(negedge clk2) begin
      logic   do_ack;
      logic   rdy;
      frame_t f;
      if (rst) begin
         check("rst_in_ready", BW'(in_ready), BW'(1));
         check("rst_out_valid", BW'(out_valid), BW'(0));
         check("rst_out_data", out_data, '0);
         check("rst_ovf", BW'(ovf), BW'(0));
         q_frames.delete();
         q_partial.delete();
         mdl_ovf = 1'b0;
      end else begin
         check("in_ready", BW'(in_ready), BW'(q_frames.size() < 2));
         check("out_valid", BW'(out_valid), BW'(q_frames.size() > 0));
         check("ovf", BW'(ovf), BW'(mdl_ovf));
         if (q_frames.size() > 0) check("out_data", out_data, expected_bus(q_frames[0]));

         rdy    = (q_frames.size() < 2);
         do_ack = out_ack && (q_frames.size() > 0);
         if (in_valid && !rdy) mdl_ovf = 1'b1;
         if (do_ack) void'(q_frames.pop_front());
         if (in_valid && rdy) begin
            if (in_sof) q_partial.delete();
            q_partial.push_back(in_data);
            if (!in_sof && q_partial.size() == NPT) begin
               for (int k = 0; k < NPT; k++) f[k] = q_partial[k];
               q_frames.push_back(f);
               q_partial.delete();
            end
         end
      end
   end

   task automatic send(input logic [N-1:0] d, input logic sof, input logic ack);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      out_ack  = ack;
      @(posedge clk2); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      out_ack  = 1'b0;
   endtask

   task automatic pulse_ack();
      out_ack = 1'b1;
      @(posedge clk2); #1;
      out_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("reset_out_valid", BW'(out_valid), BW'(0));
      check("reset_out_data", out_data, '0);
      check("reset_in_ready", BW'(in_ready), BW'(1));
      check("reset_ovf", BW'(ovf), BW'(0));
      @(posedge clk2); #1 rst = 1'b0;

      // Frame 1: samples 0..31, sof on the first.
      for (int i = 0; i < 31; i++) send(N'(i), i == 0, 1'b0);
      check("f1_not_yet_valid", BW'(out_valid), BW'(0));
      send(16'h001F, 1'b0, 1'b0);
      check("f1_valid", BW'(out_valid), BW'(1));
      check("f1_slot0", BW'(slot(0)), BW'(16'h0000));
`ifdef BITREV_EN
      check("f1_slot1", BW'(slot(1)), BW'(16'h0010));
`else
      check("f1_slot1", BW'(slot(1)), BW'(16'h0001));
`endif
      check("f1_slot31", BW'(slot(31)), BW'(16'h001F));

      // Frame 2 fills the second bank with no ack; then one rejected sample.
      for (int i = 0; i < 32; i++) send(N'(16'h0100 + i), i == 0, 1'b0);
      check("both_full_in_ready", BW'(in_ready), BW'(0));
      check("both_full_ovf_clear", BW'(ovf), BW'(0));
      send(16'hDEAD, 1'b0, 1'b0);
      check("ovf_set", BW'(ovf), BW'(1));
      check("held_frame1_slot31", BW'(slot(31)), BW'(16'h001F));

      // Ack frame 1: frame 2 shows next cycle, space frees, ovf sticks.
      pulse_ack();
      check("f2_slot0", BW'(slot(0)), BW'(16'h0100));
      check("f2_slot31", BW'(slot(31)), BW'(16'h011F));
      check("f2_in_ready", BW'(in_ready), BW'(1));
      check("ovf_sticky", BW'(ovf), BW'(1));

      // Partial frame abandoned by sof; last sample of frame 3 coincides with ack of frame 2.
      for (int i = 0; i < 10; i++) send(N'(16'h0200 + i), 1'b0, 1'b0);
      send(16'h7FFF, 1'b1, 1'b0);
      for (int j = 0; j < 30; j++) send(N'(16'h0300 + j), 1'b0, 1'b0);
      check("f3_not_replaced_yet", BW'(slot(31)), BW'(16'h011F));
      send(16'h031E, 1'b0, 1'b1);
      check("f3_valid", BW'(out_valid), BW'(1));
      check("f3_in_ready", BW'(in_ready), BW'(1));
      check("f3_slot0_sof", BW'(slot(0)), BW'(16'h7FFF));
      check("f3_index9", BW'(slot(slot_of(9))), BW'(16'h0308));
      check("f3_slot31", BW'(slot(31)), BW'(16'h031E));

      // Async reset in the middle of frame 4 (on its 17th sample).
      for (int i = 0; i < 16; i++) send(N'(16'h0500 + i), i == 0, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'h0510;
      rst      = 1'b1;
      #1;
      check("midrst_out_valid", BW'(out_valid), BW'(0));
      check("midrst_out_data", out_data, '0);
      check("midrst_ovf", BW'(ovf), BW'(0));
      check("midrst_in_ready", BW'(in_ready), BW'(1));
      @(posedge clk2); #1;
      rst      = 1'b0;
      in_valid = 1'b0;

      // Clean frame after reset.
      for (int i = 0; i < 32; i++) send(N'(16'h0400 + i), i == 0, 1'b0);
      check("f5_valid", BW'(out_valid), BW'(1));
      check("f5_slot0", BW'(slot(0)), BW'(16'h0400));
      check("f5_slot31", BW'(slot(31)), BW'(16'h041F));
      pulse_ack();
      check("f5_acked_valid", BW'(out_valid), BW'(0));
      check("f5_acked_in_ready", BW'(in_ready), BW'(1));

      repeat (3) @(posedge clk2);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
